// File: rtl/b1_pkg.sv
// Shared types and lane logic for the b1_pipe streaming block.
package b1_pkg;

  localparam int unsigned B1_WIDTH = 4;
  localparam int unsigned B1_DEPTH = 2;
  localparam int unsigned B1_CNT_W = 16;
  localparam int unsigned PTR_W    = $clog2(B1_DEPTH);

  typedef struct packed {
    logic [B1_WIDTH-1:0] d;
    logic [B1_WIDTH-1:0] e;
    logic [B1_WIDTH-1:0] f;
    logic [B1_WIDTH-1:0] g;
  } b1_res_t;

  // Per-lane b1 cone; f reduces to (a==b)&(b^c).
  function automatic b1_res_t b1_eval(input logic [B1_WIDTH-1:0] a,
                                      input logic [B1_WIDTH-1:0] b,
                                      input logic [B1_WIDTH-1:0] c);
    b1_res_t r;
    r.d = c;
    r.g = ~c;
    r.e = a ^ b;
    r.f = ~r.e & ((b & ~c) | (~a & c));
    return r;
  endfunction

endpackage

// File: rtl/b1_fifo.sv
// Generic DEPTH x DATA_W valid/ready FIFO; read data is masked to zero while empty.
module b1_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the read mask hides stale contents.
  always_ff @(posedge clock) begin
    if (push && !reset) mem[wr_ptr] <= in_data;
  end

  assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/b1_pipe.sv
// WIDTH-lane b1 cone feeding a DEPTH-entry FIFO with valid/ready on both sides.
// Optional saturating f-hit counter enabled by defining B1_PIPE_STATS_EN.
module b1_pipe
  import b1_pkg::*;
#(
  parameter int unsigned WIDTH = B1_WIDTH,
  parameter int unsigned DEPTH = B1_DEPTH,
  parameter int unsigned CNT_W = B1_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic [WIDTH-1:0] out_e,
  output logic [WIDTH-1:0] out_f,
  output logic [WIDTH-1:0] out_g
`ifdef B1_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0] f_hits
`endif
);

  b1_res_t res_in;
  b1_res_t res_out;

  // Results are computed before storage so the FIFO holds finished beats.
  assign res_in = b1_eval(in_a, in_b, in_c);

  b1_fifo #(
    .DATA_W ($bits(b1_res_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (res_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (res_out)
  );

  assign out_d = res_out.d;
  assign out_e = res_out.e;
  assign out_f = res_out.f;
  assign out_g = res_out.g;

`ifdef B1_PIPE_STATS_EN
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] HIT_MAX = '1;

  logic [SUM_W-1:0] hit_sum;
  logic             pop;

  assign pop     = out_valid & out_ready;
  assign hit_sum = {1'b0, f_hits} + SUM_W'($countones(out_f));

  // Carry out of the counter width means the count saturates.
  always_ff @(posedge clock) begin
    if (reset)    f_hits <= '0;
    else if (pop) f_hits <= hit_sum[CNT_W] ? HIT_MAX : hit_sum[CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_b1_pipe.sv
// Self-checking bench for b1_pipe: vector table, handshake sequences and a random
// stream compared against a queue-based model.
module tb_b1_pipe;

  localparam int W        = 4;
  localparam int DEPTH    = 2;
  localparam int TB_CNT_W = 4;
  localparam int HIT_MAX  = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic [W-1:0] f;
    logic [W-1:0] g;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    res_t         r;
  } vec_t;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b, in_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_d, out_e, out_f, out_g;
`ifdef B1_PIPE_STATS_EN
  logic [TB_CNT_W-1:0] f_hits;
`endif

  int   ntests = 0;
  int   nfail  = 0;
  res_t model[$];
  int   hits_m = 0;
  vec_t tbl[5];

  b1_pipe #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(TB_CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_g     (out_g)
`ifdef B1_PIPE_STATS_EN
    ,
    .f_hits    (f_hits)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Lane rule: d=c, g=~c, e=a xor b, f set where a equals b and b differs from c.
  function automatic res_t ref_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] c);
    res_t r;
    for (int l = 0; l < W; l++) begin
      r.d[l] = c[l];
      r.g[l] = !c[l];
      r.e[l] = (a[l] != b[l]);
      r.f[l] = (a[l] == b[l]) && (b[l] != c[l]);
    end
    return r;
  endfunction

  task automatic chk_out(input string tag);
    res_t e;
    e = (model.size() != 0) ? model[0] : '0;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(model.size() < DEPTH));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(model.size() != 0));
    chk({tag, " out_d"}, 32'(out_d), 32'(e.d));
    chk({tag, " out_e"}, 32'(out_e), 32'(e.e));
    chk({tag, " out_f"}, 32'(out_f), 32'(e.f));
    chk({tag, " out_g"}, 32'(out_g), 32'(e.g));
`ifdef B1_PIPE_STATS_EN
    chk({tag, " f_hits"}, 32'(f_hits), 32'(hits_m));
`endif
  endtask

  // One clock: check current outputs against the model, then advance both.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c, input logic rdy);
    logic push, pop;
    in_valid = v; in_a = a; in_b = b; in_c = c; out_ready = rdy;
    chk_out(tag);
    push = v && (model.size() < DEPTH);
    pop  = rdy && (model.size() != 0);
    @(posedge clock);
    if (pop) begin
      hits_m += $countones(model[0].f);
      if (hits_m > HIT_MAX) hits_m = HIT_MAX;
      void'(model.pop_front());
    end
    if (push) model.push_back(ref_eval(a, b, c));
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    model.delete();
    hits_m = 0;
  endtask

  initial begin
    tbl[0] = '{4'b0011, 4'b0101, 4'b0110, '{4'b0110, 4'b0110, 4'b0001, 4'b1001}};
    tbl[1] = '{4'b1111, 4'b1111, 4'b0000, '{4'b0000, 4'b0000, 4'b1111, 4'b1111}};
    tbl[2] = '{4'b0000, 4'b0000, 4'b0000, '{4'b0000, 4'b0000, 4'b0000, 4'b1111}};
    tbl[3] = '{4'b1010, 4'b0110, 4'b1100, '{4'b1100, 4'b1100, 4'b0010, 4'b0011}};
    tbl[4] = '{4'b0101, 4'b0101, 4'b1010, '{4'b1010, 4'b0000, 4'b1111, 4'b0101}};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_d", 32'(out_d), 32'd0);
    chk("rst out_g", 32'(out_g), 32'd0);
`ifdef B1_PIPE_STATS_EN
    chk("rst f_hits", 32'(f_hits), 32'd0);
`endif
    reset = 1'b0;

    // Table: single beat into an empty FIFO is visible one edge later.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = tbl[i].a; in_b = tbl[i].b; in_c = tbl[i].c; out_ready = 1'b0;
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("tbl out_valid", 32'(out_valid), 32'd1);
      chk("tbl out_d", 32'(out_d), 32'(tbl[i].r.d));
      chk("tbl out_e", 32'(out_e), 32'(tbl[i].r.e));
      chk("tbl out_f", 32'(out_f), 32'(tbl[i].r.f));
      chk("tbl out_g", 32'(out_g), 32'(tbl[i].r.g));
      out_ready = 1'b1;
      @(posedge clock); #1;
      chk("tbl drained", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end
    do_reset();

    // Backpressure: third beat waits until a pop frees a slot.
    cycle("bp1", 1'b1, 4'h3, 4'h5, 4'h6, 1'b0);
    cycle("bp2", 1'b1, 4'hA, 4'h6, 4'hC, 1'b0);
    chk("bp full", 32'(in_ready), 32'd0);
    cycle("bp3", 1'b1, 4'h5, 4'h5, 4'hA, 1'b0);
    cycle("bp4", 1'b1, 4'h5, 4'h5, 4'hA, 1'b1);
    cycle("bp5", 1'b1, 4'h5, 4'h5, 4'hA, 1'b1);
    cycle("bp6", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    cycle("bp7", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk("bp empty", 32'(out_valid), 32'd0);

    // Steady stream with simultaneous push and pop.
    for (int i = 0; i < 11; i++)
      cycle("steady", 1'b1, W'($urandom), W'($urandom), W'($urandom), 1'b1);
    cycle("steady drain", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    cycle("steady end", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

    // Reset while full with a push pending drops everything.
    cycle("rf1", 1'b1, 4'hF, 4'hF, 4'h0, 1'b0);
    cycle("rf2", 1'b1, 4'h3, 4'h5, 4'h6, 1'b0);
    reset = 1'b1; in_valid = 1'b1; in_a = 4'h5; in_b = 4'h5; in_c = 4'hA; out_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model.delete();
    hits_m = 0;
    chk("rf out_valid", 32'(out_valid), 32'd0);
    chk("rf in_ready", 32'(in_ready), 32'd1);
    chk("rf out_f", 32'(out_f), 32'd0);
    cycle("rf after", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

    // Five all-ones f beats saturate a 4-bit hit counter.
    for (int i = 0; i < 5; i++)
      cycle("sat", 1'b1, 4'hF, 4'hF, 4'h0, 1'b1);
    cycle("sat drain", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    cycle("sat end", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
`ifdef B1_PIPE_STATS_EN
    chk("sat f_hits", 32'(f_hits), 32'(HIT_MAX));
`endif
    do_reset();

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), W'($urandom),
            1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++)
      cycle("rand drain", 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
